// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the home-alarm sequencer: state encoding,
// countdown width and trip-counter saturation helper.
package alarm_sequencer_pkg;

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] TRIP_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_EXIT_WAIT  = 3'd1,
        ST_ARMED      = 3'd2,
        ST_ENTRY_WAIT = 3'd3,
        ST_ALARM      = 3'd4
    } state_e;

    // Increment the trip counter, holding at TRIP_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] trip_sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == TRIP_MAX) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Control/status bundle between the alarm panel logic and the sequencer.
// The master drives the synchronised panel events, the slave (sequencer)
// returns the display and indicator values.
interface alarm_sequencer_if;
    import alarm_sequencer_pkg::*;

    logic             tick;
    logic             arm;
    logic             disarm;
    logic             sensor;
    logic [CNT_W-1:0] countdown;
    logic [2:0]       state_code;
    logic             siren;
    logic             armed_led;
    logic [CNT_W-1:0] trip_count;

    modport master (
        output tick, arm, disarm, sensor,
        input  countdown, state_code, siren, armed_led, trip_count
    );

    modport slave (
        input  tick, arm, disarm, sensor,
        output countdown, state_code, siren, armed_led, trip_count
    );
endinterface

// File: rtl/alarm_sequencer_phase_timer.sv
// Loadable down-counter timing one alarm phase. It decrements on tick
// while the value is 2 or more and never wraps; expire flags the tick that
// lands on a value of 1, i.e. the last tick of the phase.
module phase_timer
    import alarm_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] value_q;

    // Counter register: clear beats load beats tick-driven decrement.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q <= 4'd0;
        end else if (clear) begin
            value_q <= 4'd0;
        end else if (load) begin
            value_q <= load_val;
        end else if (tick && (value_q >= 4'd2)) begin
            value_q <= value_q - 4'd1;
        end else begin
            value_q <= value_q;
        end
    end

    assign value  = value_q;
    assign expire = tick && (value_q == 4'd1);

endmodule

// File: rtl/alarm_sequencer.sv
// Home-alarm control FSM: DISARMED -> EXIT_WAIT -> ARMED -> ENTRY_WAIT ->
// ALARM -> (auto re-arm) ARMED. Every output comes from a register, so no
// input reaches an output combinationally.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned EXIT_DELAY  = 10,
    parameter int unsigned ENTRY_DELAY = 8,
    parameter int unsigned SIREN_TIME  = 12
) (
    input  logic            clk,
    input  logic            reset_n,
    alarm_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TIME);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] trip_q;
    logic [CNT_W-1:0] trip_d;
    logic             siren_q;
    logic             armed_led_q;

    logic             tmr_clear_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_load_val_s;
    logic [CNT_W-1:0] tmr_value_s;
    logic             tmr_expire_s;

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (tmr_clear_s),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .tick     (bus.tick),
        .value    (tmr_value_s),
        .expire   (tmr_expire_s)
    );

    // Next-state and timer control; disarm is checked first in every state,
    // then arm, then the timer expiry (tick), then sensor.
    always_comb begin
        state_d        = state_q;
        trip_d         = trip_q;
        tmr_clear_s    = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = 4'd0;
        case (state_q)
            ST_DISARMED: begin
                if (bus.disarm) begin
                    tmr_clear_s = 1'b1;
                end else if (bus.arm) begin
                    state_d        = ST_EXIT_WAIT;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = EXIT_LD;
                end else begin
                    state_d = ST_DISARMED;
                end
            end
            ST_EXIT_WAIT: begin
                if (bus.disarm) begin
                    state_d     = ST_DISARMED;
                    tmr_clear_s = 1'b1;
                end else if (tmr_expire_s) begin
                    state_d     = ST_ARMED;
                    tmr_clear_s = 1'b1;
                end else begin
                    state_d = ST_EXIT_WAIT;
                end
            end
            ST_ARMED: begin
                if (bus.disarm) begin
                    state_d     = ST_DISARMED;
                    tmr_clear_s = 1'b1;
                end else if (bus.sensor) begin
                    state_d        = ST_ENTRY_WAIT;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = ENTRY_LD;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ENTRY_WAIT: begin
                if (bus.disarm) begin
                    state_d     = ST_DISARMED;
                    tmr_clear_s = 1'b1;
                end else if (tmr_expire_s) begin
                    state_d        = ST_ALARM;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = SIREN_LD;
                    trip_d         = trip_sat_inc(trip_q);
                end else begin
                    state_d = ST_ENTRY_WAIT;
                end
            end
            ST_ALARM: begin
                if (bus.disarm) begin
                    state_d     = ST_DISARMED;
                    tmr_clear_s = 1'b1;
                end else if (tmr_expire_s) begin
                    state_d     = ST_ARMED;
                    tmr_clear_s = 1'b1;
                end else begin
                    state_d = ST_ALARM;
                end
            end
            default: begin
                // Codes 5-7 recover to DISARMED with the timer cleared.
                state_d     = ST_DISARMED;
                tmr_clear_s = 1'b1;
            end
        endcase
    end

    // State, trip counter and indicator registers; indicators are decoded
    // from the next state so they line up with state_code.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_DISARMED;
            trip_q      <= 4'd0;
            siren_q     <= 1'b0;
            armed_led_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            trip_q      <= trip_d;
            siren_q     <= (state_d == ST_ALARM);
            armed_led_q <= (state_d != ST_DISARMED);
        end
    end

    assign bus.countdown  = tmr_value_s;
    assign bus.state_code = state_q;
    assign bus.siren      = siren_q;
    assign bus.armed_led  = armed_led_q;
    assign bus.trip_count = trip_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default delays 10/8/12.
module tb_alarm_sequencer;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .EXIT_DELAY  (10),
        .ENTRY_DELAY (8),
        .SIREN_TIME  (12)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are read 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n = 1'b1;
        checks++;
        if (bus.state_code !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state_code); end
        checks++;
        if (bus.countdown !== 4'd0) begin errors++; $display("FAIL reset_countdown got %0d want 0", bus.countdown); end
        checks++;
        if (bus.siren !== 1'b0 || bus.armed_led !== 1'b0) begin
            errors++; $display("FAIL reset_leds got siren=%b armed=%b want 0/0", bus.siren, bus.armed_led);
        end
        checks++;
        if (bus.trip_count !== 4'd0) begin errors++; $display("FAIL reset_trip got %0d want 0", bus.trip_count); end
    endtask

    task automatic test_exit_delay();
        logic [3:0] exp_cd;
        bus.arm = 1'b1;
        cyc();
        bus.arm = 1'b0;
        checks++;
        if (bus.state_code !== 3'd1) begin errors++; $display("FAIL exit_enter_state got %0d want 1", bus.state_code); end
        for (int i = 0; i < 10; i++) begin
            repeat (4) cyc();
            exp_cd = 4'(10 - i);
            checks++;
            if (bus.countdown !== exp_cd) begin
                errors++; $display("FAIL exit_countdown step %0d got %0d want %0d", i, bus.countdown, exp_cd);
            end
            tick_once();
        end
        checks++;
        if (bus.state_code !== 3'd2) begin errors++; $display("FAIL exit_armed_state got %0d want 2", bus.state_code); end
        checks++;
        if (bus.countdown !== 4'd0 || bus.armed_led !== 1'b1) begin
            errors++; $display("FAIL exit_armed_out got cd=%0d led=%b want 0/1", bus.countdown, bus.armed_led);
        end
    endtask

    task automatic test_entry_alarm();
        logic [3:0] exp_cd;
        bus.sensor = 1'b1;
        cyc();
        bus.sensor = 1'b0;
        checks++;
        if (bus.state_code !== 3'd3) begin errors++; $display("FAIL entry_state got %0d want 3", bus.state_code); end
        for (int k = 0; k < 8; k++) begin
            repeat (2) cyc();
            exp_cd = 4'(8 - k);
            checks++;
            if (bus.countdown !== exp_cd) begin
                errors++; $display("FAIL entry_countdown step %0d got %0d want %0d", k, bus.countdown, exp_cd);
            end
            tick_once();
        end
        checks++;
        if (bus.state_code !== 3'd4 || bus.siren !== 1'b1) begin
            errors++; $display("FAIL alarm_enter got state=%0d siren=%b want 4/1", bus.state_code, bus.siren);
        end
        checks++;
        if (bus.countdown !== 4'd12 || bus.trip_count !== 4'd1) begin
            errors++; $display("FAIL alarm_values got cd=%0d trip=%0d want 12/1", bus.countdown, bus.trip_count);
        end
        for (int k = 0; k < 11; k++) begin
            cyc();
            tick_once();
        end
        checks++;
        if (bus.state_code !== 3'd4 || bus.countdown !== 4'd1) begin
            errors++; $display("FAIL alarm_last got state=%0d cd=%0d want 4/1", bus.state_code, bus.countdown);
        end
        tick_once();
        checks++;
        if (bus.state_code !== 3'd2 || bus.siren !== 1'b0 || bus.countdown !== 4'd0) begin
            errors++; $display("FAIL rearm got state=%0d siren=%b cd=%0d want 2/0/0", bus.state_code, bus.siren, bus.countdown);
        end
    endtask

    task automatic test_disarm_tick();
        bus.sensor = 1'b1;
        cyc();
        bus.sensor = 1'b0;
        repeat (5) tick_once();
        checks++;
        if (bus.state_code !== 3'd3 || bus.countdown !== 4'd3) begin
            errors++; $display("FAIL pre_disarm got state=%0d cd=%0d want 3/3", bus.state_code, bus.countdown);
        end
        bus.disarm = 1'b1;
        bus.tick   = 1'b1;
        cyc();
        bus.disarm = 1'b0;
        bus.tick   = 1'b0;
        checks++;
        if (bus.state_code !== 3'd0 || bus.countdown !== 4'd0) begin
            errors++; $display("FAIL disarm_tick got state=%0d cd=%0d want 0/0", bus.state_code, bus.countdown);
        end
        checks++;
        if (bus.trip_count !== 4'd1 || bus.armed_led !== 1'b0) begin
            errors++; $display("FAIL disarm_keep got trip=%0d led=%b want 1/0", bus.trip_count, bus.armed_led);
        end
    endtask

    task automatic test_disarmed_ignore();
        bus.arm    = 1'b1;
        bus.disarm = 1'b1;
        cyc();
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        checks++;
        if (bus.state_code !== 3'd0) begin errors++; $display("FAIL arm_disarm got %0d want 0", bus.state_code); end
        bus.sensor = 1'b1;
        repeat (3) tick_once();
        bus.sensor = 1'b0;
        checks++;
        if (bus.state_code !== 3'd0 || bus.countdown !== 4'd0) begin
            errors++; $display("FAIL disarmed_sensor got state=%0d cd=%0d want 0/0", bus.state_code, bus.countdown);
        end
    endtask

    task automatic test_saturation();
        int entries;
        int cycle;
        int last_entry;
        logic [2:0] prev_state;
        logic [3:0] exp_trip;
        entries    = 0;
        cycle      = 0;
        last_entry = 0;
        bus.arm    = 1'b1;
        bus.tick   = 1'b1;
        bus.sensor = 1'b1;
        cyc();
        bus.arm    = 1'b0;
        prev_state = bus.state_code;
        while (entries < 17 && cycle < 1000) begin
            cyc();
            cycle++;
            if (bus.state_code == 3'd4 && prev_state != 3'd4) begin
                entries++;
                exp_trip = (entries + 1 > 15) ? 4'd15 : 4'(entries + 1);
                checks++;
                if (bus.trip_count !== exp_trip) begin
                    errors++; $display("FAIL sat_trip entry %0d got %0d want %0d", entries, bus.trip_count, exp_trip);
                end
                if (entries == 1) begin
                    checks++;
                    if (cycle != 19) begin errors++; $display("FAIL sat_first_entry got cycle %0d want 19", cycle); end
                end else begin
                    checks++;
                    if (cycle - last_entry != 21) begin
                        errors++; $display("FAIL sat_period got %0d want 21", cycle - last_entry);
                    end
                end
                last_entry = cycle;
            end
            prev_state = bus.state_code;
        end
        checks++;
        if (entries != 17) begin errors++; $display("FAIL sat_timeout got %0d entries want 17", entries); end
        checks++;
        if (bus.trip_count !== 4'd15) begin errors++; $display("FAIL sat_final got %0d want 15", bus.trip_count); end
        bus.tick   = 1'b0;
        bus.sensor = 1'b0;
        bus.disarm = 1'b1;
        cyc();
        bus.disarm = 1'b0;
        checks++;
        if (bus.state_code !== 3'd0 || bus.trip_count !== 4'd15) begin
            errors++; $display("FAIL sat_disarm got state=%0d trip=%0d want 0/15", bus.state_code, bus.trip_count);
        end
    endtask

    task automatic test_reset_mid_entry();
        bus.arm  = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.arm  = 1'b0;
        repeat (10) cyc();
        bus.sensor = 1'b1;
        cyc();
        repeat (2) cyc();
        checks++;
        if (bus.state_code !== 3'd3 || bus.countdown !== 4'd6) begin
            errors++; $display("FAIL mid_entry got state=%0d cd=%0d want 3/6", bus.state_code, bus.countdown);
        end
        reset_n = 1'b0;
        repeat (2) cyc();
        reset_n    = 1'b1;
        bus.tick   = 1'b0;
        bus.sensor = 1'b0;
        checks++;
        if (bus.state_code !== 3'd0 || bus.countdown !== 4'd0 || bus.siren !== 1'b0) begin
            errors++; $display("FAIL mid_reset got state=%0d cd=%0d siren=%b want 0/0/0", bus.state_code, bus.countdown, bus.siren);
        end
        checks++;
        if (bus.trip_count !== 4'd0 || bus.armed_led !== 1'b0) begin
            errors++; $display("FAIL mid_reset_trip got trip=%0d led=%b want 0/0", bus.trip_count, bus.armed_led);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.tick   = 1'b0;
        bus.arm    = 1'b0;
        bus.disarm = 1'b0;
        bus.sensor = 1'b0;
        #2;
        test_reset();
        test_exit_delay();
        test_entry_alarm();
        test_disarm_tick();
        test_disarmed_ignore();
        test_saturation();
        test_reset_mid_entry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Home-alarm control FSM driven by the one-cycle tick pulse from the rate divider (1 Hz with rate select 01).
- Sequences the alarm through exit delay, armed, entry delay and siren phases.
- Exposes a 4-bit countdown value for direct drive of the hex decoder.
- Exposes siren and armed indicators, plus a saturating trip counter for a second display digit.

Parameters:
- EXIT_DELAY, 10, ticks between arm request and armed (legal 1..15)
- ENTRY_DELAY, 8, ticks between sensor trip and siren (legal 1..15)
- SIREN_TIME, 12, ticks siren sounds before auto re-arm (legal 1..15)

Ports:
- clk  input  1  system clock (CLOCK_50)
- reset_n  input  1  synchronous, active-low reset
- tick  input  1  one-cycle enable pulse from rate divider; may be high on consecutive cycles (rate select 00)
- arm  input  1  one-cycle arm request, already synchronised/edge-detected
- disarm  input  1  one-cycle disarm request (valid code), already synchronised
- sensor  input  1  level, 1 = door/motion tripped, already synchronised
- countdown  output  4  remaining ticks of current timed phase; 0 in DISARMED/ARMED
- state_code  output  3  current state encoding
- siren  output  1  1 only in ALARM
- armed_led  output  1  1 in every state except DISARMED
- trip_count  output  4  number of ALARM entries since reset, saturates at 15

Behaviour:
- All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
- Reset (reset_n=0 at posedge clk): state=DISARMED, countdown=0, trip_count=0, siren=0, armed_led=0. Reset overrides every other input, including mid-countdown.
- States and encodings: DISARMED=0, EXIT_WAIT=1, ARMED=2, ENTRY_WAIT=3, ALARM=4. Codes 5-7 are illegal and return to DISARMED on the next clock.
- Input priority each cycle: reset_n > disarm > arm > tick > sensor.
- DISARMED: arm -> EXIT_WAIT, countdown<=EXIT_DELAY. tick and sensor ignored.
- EXIT_WAIT: disarm -> DISARMED, countdown<=0. On tick: countdown==1 -> ARMED, countdown<=0; otherwise countdown-1. Sensor ignored. arm ignored (no reload).
- ARMED: disarm -> DISARMED. sensor==1 -> ENTRY_WAIT, countdown<=ENTRY_DELAY. tick ignored.
- ENTRY_WAIT: disarm -> DISARMED, countdown<=0. On tick: countdown==1 -> ALARM, countdown<=SIREN_TIME, trip_count+1 (saturating at 15); otherwise countdown-1. Sensor ignored.
- ALARM: disarm -> DISARMED, countdown<=0. On tick: countdown==1 -> ARMED, countdown<=0; otherwise countdown-1.
- Auto re-arm: if sensor is still 1 after ALARM -> ARMED, the FSM enters ENTRY_WAIT on the following cycle.
- Timing: each timed phase lasts exactly N ticks, where N is its parameter. The tick coinciding with the transition counts as the Nth tick. A tick in the same cycle as phase entry is not counted.
- Simultaneous events:
  - disarm+tick: disarm wins, countdown=0.
  - arm+disarm in DISARMED: stay DISARMED.
  - sensor+disarm in ARMED: DISARMED.
- Width: countdown is 4-bit and never wraps; decrement happens only when countdown>=2.

Decomposition:
- Shared package: state encoding localparams, countdown width (4), trip-count saturation value (15).
- One sub-module, phase_timer: loadable 4-bit down-counter.
  - Inputs: load, load_val, tick, clear.
  - Outputs: value, expire (tick & value==1).
  - The FSM uses expire to drive phase transitions.

Test Plan:
- reset_n=0 for 2 clocks mid-ENTRY_WAIT -> next cycle state_code=0, countdown=0, siren=0, trip_count=0.
- Arm pulse then 10 ticks spaced 5 clocks apart -> countdown reads 10,9,...,1; state_code=2 on the clock of the 10th tick; countdown=0, armed_led=1.
- In ARMED, sensor=1 then 8 ticks -> state 3, countdown 8..1, then state 4, siren=1, countdown=12, trip_count=1. Then 12 ticks with sensor=0 -> state 2, siren=0.
- In ENTRY_WAIT with countdown=3, assert disarm and tick in the same cycle -> state 0, countdown=0, trip_count unchanged.
- tick held high continuously (rate select 00), sensor held 1, 17 full alarm cycles -> trip_count saturates at 15 and never wraps to 0.
- In DISARMED, arm and disarm in the same cycle -> remains state 0; sensor=1 with ticks -> no state change.
